// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: oversample tick, serial line and received-word outputs of uart_rx_os.
`timescale 1ns/1ps
interface uart_rx_os_if #(parameter int DBIT = 8);
   logic s_tick;
   logic rx;
   logic [DBIT-1:0] dout;
   logic rx_done_tick;
   logic frame_err;
   logic parity_err;
   modport master (output s_tick, rx, input dout, rx_done_tick, frame_err, parity_err);
   modport slave (input s_tick, rx, output dout, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with break lockout.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx_os #(
   parameter int DBIT = 8,
   parameter int OVS = 16,
   parameter int SB_TICK = 16,
   parameter int PARITY_ODD = 0
) (
   input logic clk,
   input logic reset,
   uart_rx_os_if.slave bus
);
   localparam int SW = $clog2(OVS > SB_TICK ? OVS : SB_TICK);
   localparam int NW = $clog2(DBIT);
   localparam logic [SW-1:0] S_MID = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_BIT = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
   if (DBIT < 5 || DBIT > 9 || OVS < 4 || OVS % 2 != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
      $error("uart_rx_os: unsupported DBIT/OVS/PARITY_ODD");
   end
   logic [2:0] state;
   logic [SW-1:0] s;
   logic [NW-1:0] n;
   logic [DBIT-1:0] b, dout;
   logic [1:0] sync;
   logic rx_s, armed, done, frame_err;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PAR = 3'd4;
   logic par_bit, par_err;
   assign bus.parity_err = par_err;
`else
   assign bus.parity_err = 1'b0;
`endif
   assign rx_s = sync[1];
   assign bus.dout = dout;
   assign bus.rx_done_tick = done;
   assign bus.frame_err = frame_err;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         s <= '0;
         n <= '0;
         b <= '0;
         dout <= '0;
         done <= 1'b0;
         frame_err <= 1'b0;
         sync <= 2'b11;
         armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
         par_err <= 1'b0;
`endif
      end else begin
         sync <= {sync[0], bus.rx};
         done <= 1'b0;
         // a high line re-arms start detection after a break
         if (bus.s_tick && rx_s) armed <= 1'b1;
         case (state)
            IDLE: if (!rx_s && armed) begin
               state <= START;
               s <= '0;
            end
            START: if (bus.s_tick) begin
               if (s == S_MID) begin
                  state <= rx_s ? IDLE : DATA;
                  s <= '0;
                  n <= '0;
               end else s <= s + 1'b1;
            end
            DATA: if (bus.s_tick) begin
               if (s == S_BIT) begin
                  s <= '0;
                  b <= {rx_s, b[DBIT-1:1]};
                  if (n == N_LAST)
`ifdef UART_RX_PARITY_EN
                     state <= PAR;
`else
                     state <= STOP;
`endif
                  else n <= n + 1'b1;
               end else s <= s + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PAR: if (bus.s_tick) begin
               if (s == S_BIT) begin
                  s <= '0;
                  par_bit <= rx_s;
                  state <= STOP;
               end else s <= s + 1'b1;
            end
`endif
            STOP: if (bus.s_tick) begin
               if (s == S_STOP) begin
                  state <= IDLE;
                  s <= '0;
                  dout <= b;
                  frame_err <= ~rx_s;
                  done <= 1'b1;
                  if (!rx_s) armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  par_err <= ^b ^ par_bit ^ (PARITY_ODD != 0);
`endif
               end else s <= s + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames into uart_rx_os, 20 ns clk, s_tick every 4 clk, 16 ticks per bit.
`timescale 1ns/1ps
module tb_uart_rx_os;
   localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FRAME_TICKS = 8 + 8 * 16 + 16 + (PAR_EN ? 16 : 0);
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0, checks = 0;
   int n_done = 0, tick_count = 0, done_at = 0, start_at = 0, base = 0;
   logic [7:0] log_q[$];

   uart_rx_os_if #(.DBIT(8)) bus ();
   uart_rx_os dut (.clk(clk), .reset(reset), .bus(bus));

   always #10 clk = ~clk;

   initial begin
      bus.s_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus.s_tick = 1'b1;
         @(negedge clk);
         bus.s_tick = 1'b0;
      end
   end

   always @(posedge clk) if (bus.s_tick) tick_count <= tick_count + 1;

   always @(negedge clk) if (bus.rx_done_tick) begin
      n_done++;
      done_at = tick_count;
      log_q.push_back(bus.dout);
   end

   task automatic send_bit(input logic v);
      bus.rx = v;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic idle_bits(input int k);
      bus.rx = 1'b1;
      repeat (k * BIT_CLK) @(negedge clk);
   endtask

   task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
      bus.rx = 1'b0;
      repeat (3) @(negedge clk);
      start_at = tick_count;
      repeat (BIT_CLK - 3) @(negedge clk);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (PAR_EN) send_bit(par);
      send_bit(stop);
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_raw(d, ^d, 1'b1);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
      checks++; if (bus.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.rx_done_tick); end
      base = n_done;
      send_frame(8'h00);
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL zero_strobes: got %0d want 1", n_done - base); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL zero_dout: got %h want 00", bus.dout); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL zero_frame_err: got %b want 0", bus.frame_err); end
      send_frame(8'hC3);
      checks++; if (bus.dout !== 8'hC3) begin errors++; $display("FAIL pre_abort_dout: got %h want c3", bus.dout); end
      base = n_done;
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      reset = 1'b1;
      bus.rx = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_bits(2);
      checks++; if (n_done !== base) begin errors++; $display("FAIL abort_strobes: got %0d want 0", n_done - base); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL abort_dout: got %h want 00", bus.dout); end
      base = n_done;
      send_frame(8'h81);
      checks++; if (bus.dout !== 8'h81) begin errors++; $display("FAIL after_abort_dout: got %h want 81", bus.dout); end
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL after_abort_strobes: got %0d want 1", n_done - base); end
   endtask

   task automatic test_good_frame;
      idle_bits(1);
      base = n_done;
      send_frame(8'hA5);
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL good_strobes: got %0d want 1", n_done - base); end
      checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL good_dout: got %h want a5", bus.dout); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL good_frame_err: got %b want 0", bus.frame_err); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL good_parity_err: got %b want 0", bus.parity_err); end
      checks++; if (done_at - start_at !== FRAME_TICKS) begin errors++; $display("FAIL good_latency: got %0d ticks want %0d", done_at - start_at, FRAME_TICKS); end
   endtask

   task automatic test_glitch;
      idle_bits(1);
      base = n_done;
      bus.rx = 1'b0;
      repeat (16) @(negedge clk);
      idle_bits(2);
      checks++; if (n_done !== base) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", n_done - base); end
      send_frame(8'h3C);
      checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL glitch_next_dout: got %h want 3c", bus.dout); end
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL glitch_next_strobes: got %0d want 1", n_done - base); end
   endtask

   task automatic test_break;
      idle_bits(1);
      base = n_done;
      send_raw(8'h55, ^8'h55, 1'b0);
      repeat (40 * BIT_CLK) @(negedge clk);
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL break_strobes: got %0d want 1", n_done - base); end
      checks++; if (bus.dout !== 8'h55) begin errors++; $display("FAIL break_dout: got %h want 55", bus.dout); end
      checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL break_frame_err: got %b want 1", bus.frame_err); end
      idle_bits(1);
      base = n_done;
      send_frame(8'h0F);
      checks++; if (bus.dout !== 8'h0F) begin errors++; $display("FAIL rearm_dout: got %h want 0f", bus.dout); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rearm_frame_err: got %b want 0", bus.frame_err); end
      checks++; if (n_done - base !== 1) begin errors++; $display("FAIL rearm_strobes: got %0d want 1", n_done - base); end
   endtask

   task automatic test_back_to_back;
      idle_bits(1);
      log_q.delete();
      base = n_done;
      send_frame(8'h00);
      send_frame(8'hFF);
      checks++; if (n_done - base !== 2) begin errors++; $display("FAIL b2b_strobes: got %0d want 2", n_done - base); end
      if (log_q.size() == 2) begin
         checks++; if (log_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", log_q[0]); end
         checks++; if (log_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", log_q[1]); end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      idle_bits(1);
      send_raw(8'h07, 1'b1, 1'b1);
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b want 0", bus.parity_err); end
      idle_bits(1);
      send_raw(8'h07, 1'b0, 1'b1);
      checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b want 1", bus.parity_err); end
      checks++; if (bus.dout !== 8'h07) begin errors++; $display("FAIL parity_dout: got %h want 07", bus.dout); end
   endtask
`endif

   initial begin
      bus.rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_glitch();
      test_break();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
